gor_accum: RTL
==============

# gor_accum

Parametrised, registered successor to the two-input OR gate: combines `LANES` input words of `WIDTH` bits with a bitwise OR and presents the result through a valid/ready output register. It has two modes. In pass mode it emits one result per input beat. In accumulate mode it ORs across up to `ACC_LEN` beats of a frame and emits one result per frame. It sits between upstream flag/status producers and any consumer needing an "any-set" summary, e.g. interrupt or error aggregation.

## Interface
- `WIDTH`, default 4: bits per lane and width of the result.
- `LANES`, default 2: number of input lanes, ≥1.
- `ACC_LEN`, default 3: maximum beats per accumulate frame, ≥1.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: input beat present.
- `in_ready`, out, 1: block accepts the beat this cycle.
- `in_data`, in, `LANES*WIDTH`: lane k occupies bits `[k*WIDTH +: WIDTH]`.
- `in_mode`, in, 1: 0 = pass, 1 = accumulate. Sampled only on the first beat of a frame.
- `in_last`, in, 1: closes an accumulate frame early. Ignored in pass mode.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: consumer takes the result.
- `out_data`, out, `WIDTH`: OR result.
- `out_any`, out, 1: reduction OR of `out_data`.
- `out_beats`, out, `$clog2(ACC_LEN+1)`: number of beats merged into this result.

## Operation
- Accept rule: a beat is accepted when `in_valid && in_ready`.
- Ready rule: `in_ready = !rst && (!out_valid || out_ready)`. `in_ready` is combinational from `out_ready`.
- Lane OR: `lor = OR over k of lane k`.
- State machine has two states, IDLE and ACCUM. IDLE means no frame is open.
- IDLE, accepted beat with `in_mode=0`:
  - Load the output register: `out_data=lor`, `out_beats=1`, `out_valid=1`.
  - Stay in IDLE.
- IDLE, accepted beat with `in_mode=1`:
  - If `in_last` is set or `ACC_LEN==1`: load the output register with `lor`, `out_beats=1`. Stay in IDLE.
  - Otherwise: `acc=lor`, `cnt=1`, latch the mode, go to ACCUM.
- ACCUM, accepted beat:
  - Compute `nacc = acc | lor` and `ncnt = cnt+1`.
  - If `in_last` is set or `ncnt==ACC_LEN`: load the output register with `nacc` and `ncnt`, clear `acc`, go to IDLE.
  - Otherwise: `acc=nacc`, `cnt=ncnt`, stay in ACCUM.
  - `in_mode` is ignored while in ACCUM.
- Output register:
  - `out_valid` clears on `out_ready` when no new load occurs in the same cycle.
  - A load in the same cycle as a drain keeps `out_valid=1` with the new contents.
  - While `out_valid && !out_ready`, all `out_*` outputs hold stable.
- `out_any` is registered alongside `out_data`. It equals `|out_data` at all times.
- Back-to-back frames: the beat after a closing beat starts a fresh frame. It never merges into the previous accumulator.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_any=0`, `out_beats=0`, `acc=0`, `cnt=0`, state IDLE. `in_ready=0` while `rst` is high and 1 in the first cycle after.
- Reset mid-frame discards the partial accumulator and any pending unaccepted output.
- Pass latency: the result is valid 1 cycle after the accepted beat. Throughput is 1 beat/cycle when `out_ready=1`.
- Accumulate latency: the result is valid 1 cycle after the closing beat. Non-closing beats are accepted whenever `in_ready=1`.
- Backpressure: with `out_valid=1` and `out_ready=0`, `in_ready=0`, so no beats are accepted, including non-closing ones.
- No combinational path from `in_valid`/`in_data` to any `out_*` output.
- `cnt` never exceeds `ACC_LEN`; the frame closes at equality.

## Test plan
Test parameters: `WIDTH=4`, `LANES=2`, `ACC_LEN=3`.
- Reset check: assert `rst` for 2 cycles with `in_valid=1` -> all outputs 0 and `in_ready=0` during reset; nothing accepted; `in_ready=1` the cycle after.
- Pass sweep: mode 0, beats `{0000,0000}`, `{0001,1000}`, `{0110,0000}` on consecutive cycles, `out_ready=1` -> results `0000/any0`, `1001/any1`, `0110/any1`, each 1 cycle later, all with `out_beats=1`.
- Full accumulate frame: mode 1, beats `{0001,0000}`, `{0000,0100}`, `{0000,0000}` -> a single result `0101`, `any=1`, `out_beats=3`, 1 cycle after the third beat.
- Early close plus back-to-back: mode 1, beat `{1000,0000}` then `{0000,0000}` with `in_last=1`, then immediately a mode 0 beat `{0010,0000}` -> results `1000` with `out_beats=2`, then `0010` with `out_beats=1`, no merging.
- Backpressure: hold `out_ready=0` with `out_valid=1` for 4 cycles while `in_valid=1` -> `in_ready=0` and outputs stable; raise `out_ready` -> drained result plus the next beat accepted in the same cycle.
- Reset mid-frame: after 2 accumulate beats, pulse `rst` -> no output; the next mode 1 frame of `{0001,0000}` × 3 yields `0001` with `out_beats=3`.

Source files
------------

// File: rtl/gor_accum.sv
// rtl/gor_accum.sv - multi-lane OR with pass and frame-accumulate modes behind a valid/ready output register

module gor_accum #(
   parameter int WIDTH   = 4,
   parameter int LANES   = 2,
   parameter int ACC_LEN = 3
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [LANES*WIDTH-1:0]             in_data,
   input  logic                               in_mode,
   input  logic                               in_last,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [WIDTH-1:0]                   out_data,
   output logic                               out_any,
   output logic [$clog2(ACC_LEN+1)-1:0]       out_beats
);

   localparam int CW = $clog2(ACC_LEN+1);
   localparam bit SINGLE_BEAT = (ACC_LEN == 1);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] lor;
   logic [WIDTH-1:0] nacc;
   logic [CW-1:0]    ncnt;
   logic             accept;
   logic             load;
   logic [WIDTH-1:0] load_data;
   logic [CW-1:0]    load_beats;

   // The block can take a beat whenever the output slot is empty or being drained this cycle.
   assign in_ready = !rst && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // OR all lanes of the incoming beat together.
   always_comb begin
      lor = '0;
      for (int k = 0; k < LANES; k++) begin
         lor = lor | in_data[k*WIDTH +: WIDTH];
      end
   end

   assign nacc = acc | lor;
   assign ncnt = cnt + CW'(1);

   // Frame control: decides when a result is loaded and how the accumulator evolves.
   // ACCUM is only ever entered from an accumulate-mode first beat, so the state itself
   // carries the latched mode and in_mode is ignored while a frame is open.
   always_comb begin
      state_nxt  = state;
      acc_nxt    = acc;
      cnt_nxt    = cnt;
      load       = 1'b0;
      load_data  = lor;
      load_beats = CW'(1);
      case (state)
         IDLE: begin
            if (accept) begin
               if (!in_mode || in_last || SINGLE_BEAT) begin
                  load = 1'b1;
               end else begin
                  acc_nxt   = lor;
                  cnt_nxt   = CW'(1);
                  state_nxt = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (accept) begin
               if (in_last || ncnt == CW'(ACC_LEN)) begin
                  load       = 1'b1;
                  load_data  = nacc;
                  load_beats = ncnt;
                  acc_nxt    = '0;
                  cnt_nxt    = '0;
                  state_nxt  = IDLE;
               end else begin
                  acc_nxt = nacc;
                  cnt_nxt = ncnt;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Frame state register; reset drops any partially accumulated frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Output register: a load wins over a drain, otherwise a drain empties the slot and
   // the contents are left untouched so out_any keeps tracking out_data.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_any   <= 1'b0;
         out_beats <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_any   <= |load_data;
         out_beats <= load_beats;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
